// File: rtl/prbs_pkg.sv
// prbs_pkg: shared FSM state type, LFSR taps, default seed and byte-index width
// for the PRBS-15 pattern generator (optional error injection: PRBS_ERR_INJ_EN).
package prbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PAT  = 2'd1,
    PRBS = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Feedback taps of x^15 + x^14 + 1 (state bits 14 and 13)
  localparam int TAP_HI = 14;
  localparam int TAP_LO = 13;

  // Any non-zero value works; all-ones is the conventional PRBS-15 start point
  localparam logic [14:0] DEFAULT_SEED = 15'h7FFF;

  // Pattern word is four bytes, so two bits select the byte
  localparam int IDX_W = 2;

  // Single LFSR step: feedback enters at bit 0, everything shifts toward the MSB
  function automatic logic [14:0] lfsrStep(input logic [14:0] s);
    return {s[13:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/prbs15_lfsr8.sv
// prbs15_lfsr8: PRBS-15 LFSR that advances a whole byte (eight steps) at a time.
// byte_out always shows the byte the next advance will produce.
module prbs15_lfsr8
  import prbs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [14:0] seed,
  input  logic        adv,
  output logic [7:0]  byte_out
);

  logic [14:0] r_state;
  logic [14:0] w_next;
  logic [7:0]  w_byte;

  // Unrolled eight steps; the first feedback bit ends up in the byte MSB
  always_comb begin
    w_next = r_state;
    w_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_byte = {w_byte[6:0], w_next[TAP_HI] ^ w_next[TAP_LO]};
      w_next = lfsrStep(w_next);
    end
  end

  // Reset and load restart from the seed; adv moves the state one byte ahead
  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_state <= seed;
    end else if (adv) begin
      r_state <= w_next;
    end
  end

  assign byte_out = w_byte;

endmodule

// File: rtl/prbs15_pattern_gen.sv
// prbs15_pattern_gen: emits a 32-bit user pattern n_reps times (MSB byte first),
// then prbs_len bytes of PRBS-15, over a valid/ready byte stream.
// Optional macro PRBS_ERR_INJ_EN adds err_inj, which flips bit 0 of one PRBS byte.
module prbs15_pattern_gen
  import prbs_pkg::*;
#(
  parameter logic [14:0] SEED  = DEFAULT_SEED,
  parameter int          REP_W = 8,
  parameter int          LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      pattern_in,
  input  logic [REP_W-1:0] n_reps,
  input  logic [LEN_W-1:0] prbs_len,
`ifdef PRBS_ERR_INJ_EN
  input  logic             err_inj,
`endif
  input  logic             out_ready,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [31:0]      r_pattern;
  logic [REP_W-1:0] r_nReps;
  logic [REP_W-1:0] r_repCnt;
  logic [LEN_W-1:0] r_prbsLen;
  logic [LEN_W-1:0] r_byteCnt;
  logic [IDX_W-1:0] r_byteIdx;
  logic             r_dataValid;
  logic             r_busy;
  logic             r_done;

  logic             w_xfer;
  logic             w_startAcc;
  logic             w_lfsrAdv;
  logic [REP_W-1:0] w_repNext;
  logic [LEN_W-1:0] w_byteNext;
  logic [7:0]       w_lfsrByte;
  logic [7:0]       w_errMask;
  logic [7:0]       w_dataOut;

  assign w_xfer     = r_dataValid && out_ready;
  assign w_startAcc = (r_state == IDLE) && start;
  assign w_lfsrAdv  = (r_state == PRBS) && w_xfer;
  assign w_repNext  = r_repCnt + REP_W'(1);
  assign w_byteNext = r_byteCnt + LEN_W'(1);

  prbs15_lfsr8 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (w_startAcc),
    .seed     (SEED),
    .adv      (w_lfsrAdv),
    .byte_out (w_lfsrByte)
  );

  // Run sequencer: latches the request, walks pattern and PRBS phases on transfers, pulses done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pattern   <= '0;
      r_nReps     <= '0;
      r_prbsLen   <= '0;
      r_repCnt    <= '0;
      r_byteCnt   <= '0;
      r_byteIdx   <= '0;
      r_dataValid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_pattern <= pattern_in;
            r_nReps   <= n_reps;
            r_prbsLen <= prbs_len;
            r_repCnt  <= '0;
            r_byteCnt <= '0;
            r_byteIdx <= '0;
            if (n_reps != '0) begin
              r_state     <= PAT;
              r_dataValid <= 1'b1;
              r_busy      <= 1'b1;
            end else if (prbs_len != '0) begin
              r_state     <= PRBS;
              r_dataValid <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              r_state     <= FIN;
              r_dataValid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end
          end
        end
        PAT: begin
          if (w_xfer) begin
            r_byteIdx <= r_byteIdx + IDX_W'(1);
            if (r_byteIdx == IDX_W'(3)) begin
              r_repCnt <= w_repNext;
              if (w_repNext == r_nReps) begin
                if (r_prbsLen != '0) begin
                  r_state <= PRBS;
                end else begin
                  r_state     <= FIN;
                  r_dataValid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                end
              end
            end
          end
        end
        PRBS: begin
          if (w_xfer) begin
            r_byteCnt <= w_byteNext;
            if (w_byteNext == r_prbsLen) begin
              r_state     <= FIN;
              r_dataValid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end
          end
        end
        FIN: begin
          r_state     <= IDLE;
          r_dataValid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_dataValid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

`ifdef PRBS_ERR_INJ_EN
  logic r_errArmed;

  // Sticky injection request: armed by err_inj, consumed by the next PRBS transfer, dropped by a new run
  always_ff @(posedge clk) begin
    if (rst || w_startAcc) begin
      r_errArmed <= 1'b0;
    end else if (err_inj) begin
      r_errArmed <= 1'b1;
    end else if (w_lfsrAdv) begin
      r_errArmed <= 1'b0;
    end
  end

  assign w_errMask = {7'b0, r_errArmed};
`else
  assign w_errMask = 8'h00;
`endif

  // Output byte follows registered state only, so it holds steady while the consumer stalls
  always_comb begin
    w_dataOut = 8'h00;
    case (r_state)
      PAT: begin
        case (r_byteIdx)
          2'd0:    w_dataOut = r_pattern[31:24];
          2'd1:    w_dataOut = r_pattern[23:16];
          2'd2:    w_dataOut = r_pattern[15:8];
          default: w_dataOut = r_pattern[7:0];
        endcase
      end
      PRBS:    w_dataOut = w_lfsrByte ^ w_errMask;
      default: w_dataOut = 8'h00;
    endcase
  end

  assign data_out   = w_dataOut;
  assign data_valid = r_dataValid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_prbs15_pattern_gen.sv
// tb_prbs15_pattern_gen: table-driven and randomized bench for prbs15_pattern_gen.
// Expected bytes come from a bit-sequence PRBS model plus a queue of pattern bytes.
module tb_prbs15_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pattern_in = '0;
  logic [7:0]  n_reps = '0;
  logic [15:0] prbs_len = '0;
  logic        out_ready = 1'b0;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        busy;
  logic        done;
`ifdef PRBS_ERR_INJ_EN
  logic        err_inj = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  bit          prbsBits[0:2047];
  byte unsigned expQ[$];

  typedef struct {
    logic [31:0] pattern;
    int          reps;
    int          len;
    int          readyMode;
    int          expCount;
    logic [7:0]  expFirst;
    int          expDoneCycle;
  } vec_t;

  vec_t vecs[6];

  prbs15_pattern_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern_in (pattern_in),
    .n_reps     (n_reps),
    .prbs_len   (prbs_len),
`ifdef PRBS_ERR_INJ_EN
    .err_inj    (err_inj),
`endif
    .out_ready  (out_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // PRBS-15 as a bit recurrence: b[n] = b[n-15] ^ b[n-14], seed bits oldest first
  task automatic buildPrbsBits(input logic [14:0] seedv);
    for (int i = 0; i < 15; i++) prbsBits[i] = seedv[14-i];
    for (int n = 15; n < 2048; n++) prbsBits[n] = prbsBits[n-15] ^ prbsBits[n-14];
  endtask

  function automatic logic [7:0] modelPrbsByte(input int k);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], prbsBits[15 + 8*k + i]};
    return b;
  endfunction

  task automatic buildExpected(input logic [31:0] pat, input int reps, input int len);
    expQ.delete();
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < 4; i++) expQ.push_back(pat[31 - 8*i -: 8]);
    for (int k = 0; k < len; k++) expQ.push_back(modelPrbsByte(k));
  endtask

  // Issues a one-cycle start, then scrambles the inputs to prove they were latched
  task automatic applyStimulus(input logic [31:0] pat, input int reps, input int len);
    pattern_in = pat;
    n_reps     = 8'(reps);
    prbs_len   = 16'(len);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    pattern_in = ~pat;
    n_reps     = 8'($urandom_range(1, 9));
    prbs_len   = 16'($urandom_range(1, 9));
  endtask

  task automatic runStream(input string name, input logic [31:0] pat, input int reps,
                           input int len, input int mode, input int expCount,
                           input logic [7:0] expFirst, input int expDoneCycle,
                           input int midStart, input int errAt);
    int         cycle;
    int         xfers;
    int         budget;
    bit         doneSeen;
    bit         heldPending;
    logic [7:0] held;
    cycle = 1;
    xfers = 0;
    doneSeen = 0;
    heldPending = 0;
    held = 8'h00;
    budget = expCount * 8 + 20;
    buildExpected(pat, reps, len);
`ifdef PRBS_ERR_INJ_EN
    if (errAt > 0 && len > 0) expQ[4*reps] = expQ[4*reps] ^ 8'h01;
`endif
    applyStimulus(pat, reps, len);
    if (expCount > 0) begin
      checkOutput({name, " first_valid"}, data_valid, 1);
      checkOutput({name, " first_busy"}, busy, 1);
      checkOutput({name, " first_byte"}, data_out, expFirst);
    end else begin
      checkOutput({name, " degenerate_done"}, done, 1);
      checkOutput({name, " degenerate_valid"}, data_valid, 0);
    end
    while (cycle <= budget) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = ((cycle % 4) == 1) || ((cycle % 4) == 0);
      endcase
      start = (cycle == midStart);
      if (start) begin
        pattern_in = 32'hFFFF_FFFF;
        n_reps     = 8'd9;
        prbs_len   = 16'd9;
      end
`ifdef PRBS_ERR_INJ_EN
      err_inj = (cycle == errAt);
`endif
      if (heldPending) begin
        checkOutput({name, " hold_valid"}, data_valid, 1);
        checkOutput({name, " hold_byte"}, data_out, held);
        heldPending = 0;
      end
      if (done) begin
        doneSeen = 1;
        checkOutput({name, " done_valid"}, data_valid, 0);
        if (expDoneCycle > 0) checkOutput({name, " done_cycle"}, cycle, expDoneCycle);
        break;
      end
      if (data_valid) begin
        if (out_ready) begin
          xfers++;
          if (expQ.size() == 0) checkOutput({name, " extra_byte"}, 1, 0);
          else checkOutput({name, " byte"}, data_out, expQ.pop_front());
        end else begin
          held = data_out;
          heldPending = 1;
        end
      end
      tick();
      cycle++;
    end
    start = 1'b0;
`ifdef PRBS_ERR_INJ_EN
    err_inj = 1'b0;
`endif
    checkOutput({name, " done_seen"}, doneSeen, 1);
    checkOutput({name, " xfer_count"}, xfers, expCount);
    checkOutput({name, " bytes_left"}, expQ.size(), 0);
    if (doneSeen) begin
      tick();
      checkOutput({name, " done_width"}, done, 0);
      checkOutput({name, " busy_after"}, busy, 0);
    end
  endtask

  initial begin
    int reps;
    int len;
    logic [31:0] pat;
    logic [7:0] first;

    buildPrbsBits(15'h7FFF);

    // pattern, reps, len, readyMode, expCount, expFirst, expDoneCycle
    vecs[0] = '{32'hA5C3_0F96, 2, 0, 0, 8,  8'hA5, 9};
    vecs[1] = '{32'h0000_0000, 0, 3, 0, 3,  8'h00, 4};
    vecs[2] = '{32'h1234_5678, 1, 2, 2, 6,  8'h12, 0};
    vecs[3] = '{32'h5555_AAAA, 0, 0, 0, 0,  8'h00, 1};
    vecs[4] = '{32'hDEAD_BEEF, 1, 5, 1, 9,  8'hDE, 0};
    vecs[5] = '{32'h0102_0304, 3, 1, 0, 13, 8'h01, 14};

    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset data_out", data_out, 0);
    checkOutput("reset data_valid", data_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    rst = 1'b0;
    tick();

    // Table vectors
    for (int v = 0; v < 6; v++) begin
      runStream($sformatf("vec%0d", v), vecs[v].pattern, vecs[v].reps, vecs[v].len,
                vecs[v].readyMode, vecs[v].expCount, vecs[v].expFirst,
                vecs[v].expDoneCycle, 0, 0);
      tick();
    end

    // Spot-check the model itself against the known seed stream
    checkOutput("model prbs0", modelPrbsByte(0), 8'h00);
    checkOutput("model prbs1", modelPrbsByte(1), 8'h02);

    // Start pulsed mid-run must not disturb the stream
    runStream("midstart", 32'h1122_3344, 1, 4, 0, 8, 8'h11, 9, 3, 0);
    tick();

    // Start held through the FIN cycle is ignored there
    pattern_in = 32'hCAFE_0001;
    n_reps     = 8'd0;
    prbs_len   = 16'd0;
    start      = 1'b1;
    tick();
    checkOutput("finstart done", done, 1);
    n_reps = 8'd2;
    tick();
    start = 1'b0;
    checkOutput("finstart busy", busy, 0);
    checkOutput("finstart valid", data_valid, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Reset while the third PRBS byte is on the bus
    pattern_in = 32'h0;
    n_reps     = 8'd0;
    prbs_len   = 16'd6;
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("rstmid byte0", data_out, modelPrbsByte(0));
    tick();
    checkOutput("rstmid byte1", data_out, modelPrbsByte(1));
    tick();
    checkOutput("rstmid byte2", data_out, modelPrbsByte(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstmid data_out", data_out, 0);
    checkOutput("rstmid valid", data_valid, 0);
    checkOutput("rstmid busy", busy, 0);
    checkOutput("rstmid done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rstmid no_done", done, 0);
    end
    runStream("after_rst", 32'h0, 0, 3, 0, 3, 8'h00, 4, 0, 0);
    tick();

`ifdef PRBS_ERR_INJ_EN
    runStream("errinj", 32'hCAFE_F00D, 1, 2, 0, 6, 8'hCA, 7, 0, 2);
    tick();
    runStream("errclean", 32'h0, 0, 3, 0, 3, 8'h00, 4, 0, 0);
    tick();
`endif

    // Randomized runs with random backpressure
    for (int r = 0; r < 8; r++) begin
      reps  = $urandom_range(0, 3);
      len   = $urandom_range(0, 24);
      pat   = $urandom;
      first = (reps > 0) ? pat[31:24] : modelPrbsByte(0);
      runStream($sformatf("rand%0d", r), pat, reps, len, 1, 4*reps + len, first, 0, 0, 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
